// File: rtl/sonar_tx_pkg.sv
// Shared types and constants for the sonar transmit/echo-timing block.
package sonar_tx_pkg;

  // Ping sequencer states; encoding is visible on debug taps, keep it stable.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBurst  = 2'd1,
    StBlank  = 2'd2,
    StListen = 2'd3
  } state_e;

  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned BURST_W_DEFAULT = 8;

  // Reported time-of-flight when the listen window closes without an echo.
  localparam logic [CNT_W_DEFAULT-1:0] TOF_TIMEOUT = '1;

endpackage : sonar_tx_pkg

// File: rtl/sonar_carrier_gen.sv
// Differential carrier generator for the ultrasonic burst.
// en_i is high when the following cycle is a burst cycle; the first enabled
// cycle after an idle one starts the carrier high. done_o flags the last
// cycle of the final low half-period.
module sonar_carrier_gen
  import sonar_tx_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned BURST_W = BURST_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   half_period_i,  // already clamped to >= 1
  input  logic [BURST_W-1:0] burst_len_i,    // >= 1 whenever en_i is used
  output logic               tx_p_o,
  output logic               tx_n_o,
  output logic               done_o
);

  logic               run_q, run_d;
  logic               tx_p_q, tx_p_d;
  logic               tx_n_q, tx_n_d;
  logic [CNT_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [BURST_W-1:0] cyc_q, cyc_d;
  logic               half_end;

  assign half_end = (hp_cnt_q == half_period_i - CNT_W'(1));
  assign done_o   = run_q & ~tx_p_q & half_end & (cyc_q == burst_len_i - BURST_W'(1));
  assign tx_p_o   = tx_p_q;
  assign tx_n_o   = tx_n_q;

  // Next carrier phase: restart high on entry, toggle at each half-period end.
  always_comb begin
    run_d    = run_q;
    tx_p_d   = tx_p_q;
    tx_n_d   = tx_n_q;
    hp_cnt_d = hp_cnt_q;
    cyc_d    = cyc_q;
    if (clear_i || !en_i) begin
      run_d    = 1'b0;
      tx_p_d   = 1'b0;
      tx_n_d   = 1'b0;
      hp_cnt_d = '0;
      cyc_d    = '0;
    end else if (!run_q) begin
      run_d    = 1'b1;
      tx_p_d   = 1'b1;
      tx_n_d   = 1'b0;
      hp_cnt_d = '0;
      cyc_d    = '0;
    end else if (half_end) begin
      hp_cnt_d = '0;
      tx_p_d   = ~tx_p_q;
      tx_n_d   = tx_p_q;
      // A full carrier cycle ends with its low half.
      if (!tx_p_q) begin
        cyc_d = cyc_q + BURST_W'(1);
      end
    end else begin
      hp_cnt_d = hp_cnt_q + CNT_W'(1);
    end
  end

  // Carrier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      tx_p_q   <= 1'b0;
      tx_n_q   <= 1'b0;
      hp_cnt_q <= '0;
      cyc_q    <= '0;
    end else begin
      run_q    <= run_d;
      tx_p_q   <= tx_p_d;
      tx_n_q   <= tx_n_d;
      hp_cnt_q <= hp_cnt_d;
      cyc_q    <= cyc_d;
    end
  end

endmodule : sonar_carrier_gen

// File: rtl/sonar_ping_tx.sv
// Sonar ping transmitter: burst drive, receive blanking and first-echo timing.
// Time-of-flight is counted in clk cycles from the first cycle after start.
module sonar_ping_tx
  import sonar_tx_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned BURST_W = BURST_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [CNT_W-1:0]   blank_len,
  input  logic [CNT_W-1:0]   listen_len,
  input  logic               echo_in,
  output logic               tx_p,
  output logic               tx_n,
  output logic               blank,
  output logic               busy,
  output logic [CNT_W-1:0]   tof,
  output logic               tof_valid,
  output logic               timeout
);

  state_e             state_q;
  logic [CNT_W-1:0]   hp_q;           // shadow, clamped to >= 1
  logic [BURST_W-1:0] burst_len_q;
  logic [CNT_W-1:0]   blank_len_q;
  logic [CNT_W-1:0]   listen_len_q;
  logic [CNT_W-1:0]   tof_cnt_q;
  logic [CNT_W-1:0]   timer_q;        // shared by BLANK and LISTEN
  logic [CNT_W-1:0]   tof_q;
  logic               echo_prev_q;
  logic               blank_q;
  logic               busy_q;
  logic               tof_valid_q;
  logic               timeout_q;

  logic               echo_rise;
  logic               launch_burst;
  logic               carrier_en;
  logic               carrier_done;
  logic               blank_last;

  assign echo_rise    = echo_in & ~echo_prev_q;
  assign launch_burst = (state_q == StIdle) & start & ~abort & (burst_len != '0);
  // High when the next cycle is a burst cycle.
  assign carrier_en   = launch_burst | ((state_q == StBurst) & ~carrier_done);
  // Zero-length blanking still spends one cycle in BLANK.
  assign blank_last   = (blank_len_q == '0) | (timer_q == blank_len_q - CNT_W'(1));

  sonar_carrier_gen #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) u_carrier (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (abort),
    .en_i          (carrier_en),
    .half_period_i (hp_q),
    .burst_len_i   (burst_len_q),
    .tx_p_o        (tx_p),
    .tx_n_o        (tx_n),
    .done_o        (carrier_done)
  );

  // Ping sequencer, timers, echo edge detect and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      hp_q         <= CNT_W'(1);
      burst_len_q  <= '0;
      blank_len_q  <= '0;
      listen_len_q <= '0;
      tof_cnt_q    <= '0;
      timer_q      <= '0;
      tof_q        <= '0;
      echo_prev_q  <= 1'b0;
      blank_q      <= 1'b0;
      busy_q       <= 1'b0;
      tof_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      echo_prev_q <= echo_in;
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (tof_cnt_q != '1) begin
        tof_cnt_q <= tof_cnt_q + CNT_W'(1);
      end

      if (abort) begin
        state_q <= StIdle;
        blank_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              hp_q         <= (half_period == '0) ? CNT_W'(1) : half_period;
              burst_len_q  <= burst_len;
              blank_len_q  <= blank_len;
              listen_len_q <= listen_len;
              tof_cnt_q    <= '0;
              timer_q      <= '0;
              busy_q       <= 1'b1;
              blank_q      <= 1'b1;
              state_q      <= (burst_len != '0) ? StBurst : StBlank;
            end
          end
          StBurst: begin
            if (carrier_done) begin
              timer_q <= '0;
              state_q <= StBlank;
            end
          end
          StBlank: begin
            if (blank_last) begin
              timer_q <= '0;
              blank_q <= 1'b0;
              state_q <= StListen;
            end else begin
              timer_q <= timer_q + CNT_W'(1);
            end
          end
          StListen: begin
            // An echo on the expiry cycle still counts as an echo.
            if (echo_rise) begin
              tof_q       <= tof_cnt_q;
              tof_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end else if (timer_q == listen_len_q) begin
              tof_q     <= '1;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              timer_q <= timer_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            blank_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign blank     = blank_q;
  assign busy      = busy_q;
  assign tof       = tof_q;
  assign tof_valid = tof_valid_q;
  assign timeout   = timeout_q;

endmodule : sonar_ping_tx

// File: tb/tb_sonar_ping_tx.sv
// Bench for sonar_ping_tx: directed test-plan pings plus randomized pings,
// each checked cycle by cycle against a closed-form timeline of the ping.
module tb_sonar_ping_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] half_period;
  logic [7:0]  burst_len;
  logic [15:0] blank_len;
  logic [15:0] listen_len;
  logic        echo_in;
  logic        tx_p;
  logic        tx_n;
  logic        blank;
  logic        busy;
  logic [15:0] tof;
  logic        tof_valid;
  logic        timeout;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_tof;
  bit          echo_arr [0:1023];

  sonar_ping_tx #(
    .CNT_W   (16),
    .BURST_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .half_period (half_period),
    .burst_len   (burst_len),
    .blank_len   (blank_len),
    .listen_len  (listen_len),
    .echo_in     (echo_in),
    .tx_p        (tx_p),
    .tx_n        (tx_n),
    .blank       (blank),
    .busy        (busy),
    .tof         (tof),
    .tof_valid   (tof_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_echo();
    for (int i = 0; i < 1024; i++) echo_arr[i] = 1'b0;
  endtask

  task automatic rand_echo();
    bit lvl;
    lvl = 1'($urandom_range(0, 1));
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 11) == 0) lvl = ~lvl;
      echo_arr[i] = lvl;
    end
  endtask

  task automatic chk_quiet(input string tag, input int k);
    chk({tag, ".tx_p"}, k, tx_p, 0);
    chk({tag, ".tx_n"}, k, tx_n, 0);
    chk({tag, ".blank"}, k, blank, 0);
    chk({tag, ".busy"}, k, busy, 0);
    chk({tag, ".tof_valid"}, k, tof_valid, 0);
    chk({tag, ".timeout"}, k, timeout, 0);
  endtask

  // One ping. Expected timeline: burst of 2*hp*bl cycles, blanking of
  // max(blank,1) cycles, then a window of listen+1 cycles for a rising edge.
  // echo_arr[k] is the echo level driven during cycle k (cycle 0 = first
  // cycle after start is accepted).
  task automatic run_ping(input int hp, input int bl, input int bk, input int ln,
                          input bit poke);
    int hpe, nb, l0, win_end, hit, endk;
    bit prev, etx;
    hpe     = (hp == 0) ? 1 : hp;
    nb      = 2 * hpe * bl;
    l0      = nb + ((bk == 0) ? 1 : bk);
    win_end = l0 + ln;
    hit     = -1;
    for (int k = l0; k <= win_end; k++) begin
      prev = (k == 0) ? 1'b0 : echo_arr[k-1];
      if (hit < 0 && echo_arr[k] && !prev) hit = k;
    end
    endk = (hit >= 0) ? hit + 1 : win_end + 1;

    echo_in     = 1'b0;
    half_period = 16'(hp);
    burst_len   = 8'(bl);
    blank_len   = 16'(bk);
    listen_len  = 16'(ln);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= endk + 1; k++) begin
      etx = (k < nb) && (((k / hpe) % 2) == 0);
      chk("tx_p", k, tx_p, etx);
      chk("tx_n", k, tx_n, (k < nb) && !etx);
      chk("blank", k, blank, k < l0);
      chk("busy", k, busy, k < endk);
      chk("tof_valid", k, tof_valid, (k == endk) && (hit >= 0));
      chk("timeout", k, timeout, (k == endk) && (hit < 0));
      if (k == endk) begin
        last_tof = (hit >= 0) ? 16'(hit) : 16'hFFFF;
        chk("tof", k, tof, last_tof);
      end
      echo_in     = (k < endk) ? echo_arr[k] : 1'b0;
      half_period = 16'($urandom);
      burst_len   = 8'($urandom);
      blank_len   = 16'($urandom);
      listen_len  = 16'($urandom);
      start       = poke && (k == 3) && (endk > 5);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    echo_in     = 1'b0;
    half_period = '0;
    burst_len   = '0;
    blank_len   = '0;
    listen_len  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset", 0);
    chk("reset.tof", 0, tof, 0);
    rst = 1'b0;
    last_tof = 16'h0;
    tick();

    // Single echo pulse at tof_cnt 40.
    clear_echo();
    echo_arr[40] = 1'b1;
    run_ping(4, 2, 10, 100, 1'b0);

    // Echo level already high before LISTEN: no edge, so timeout.
    clear_echo();
    for (int i = 5; i < 1024; i++) echo_arr[i] = 1'b1;
    run_ping(4, 2, 10, 100, 1'b0);

    // Edge during BLANK ignored; second edge at 30 counts.
    clear_echo();
    echo_arr[20] = 1'b1;
    echo_arr[21] = 1'b1;
    for (int i = 30; i < 1024; i++) echo_arr[i] = 1'b1;
    run_ping(4, 2, 10, 100, 1'b0);

    // Abort during BURST at cycle 7.
    half_period = 16'd4;
    burst_len   = 8'd2;
    blank_len   = 16'd10;
    listen_len  = 16'd100;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_abort.tx_n", 7, tx_n, 1);
    chk("pre_abort.busy", 7, busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort", 8);
    chk("abort.tof", 8, tof, last_tof);
    tick();
    chk_quiet("abort", 9);
    clear_echo();
    echo_arr[40] = 1'b1;
    run_ping(4, 2, 10, 100, 1'b0);

    // Degenerate lengths and half_period 0.
    clear_echo();
    run_ping(0, 0, 0, 0, 1'b0);
    run_ping(0, 2, 3, 5, 1'b0);

    // start and abort together in IDLE: not started.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_quiet("start_abort", 0);
    tick();
    chk_quiet("start_abort", 1);

    // Start while busy is ignored; end time unchanged.
    clear_echo();
    run_ping(3, 2, 4, 30, 1'b1);

    // Asynchronous reset mid-LISTEN.
    clear_echo();
    half_period = 16'd2;
    burst_len   = 8'd1;
    blank_len   = 16'd3;
    listen_len  = 16'd50;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_rst.busy", 10, busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("async_rst", 10);
    chk("async_rst.tof", 10, tof, 0);
    @(negedge clk);
    rst = 1'b0;
    last_tof = 16'h0;
    tick();
    chk_quiet("post_rst", 11);

    // Randomized pings.
    for (int r = 0; r < 15; r++) begin
      rand_echo();
      run_ping(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 40)),
               1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sonar_ping_tx
